sdmem_arbiter: RTL

// - Shares the single data-memory port (sdatamem) between the scalar LSU and the vector LSU.
// - Scalar side: single accesses. Vector side: strided bursts (base, stride, count) expanded here into per-element accesses.
// - Drives sdatamem read/write/size/addr/wdata; registers the combinational read data into per-requester responses.

---
 rtl/sdmem_arb_pkg.sv | 12 +
 rtl/sdmem_vec_agen.sv | 38 +++
 rtl/sdmem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sdmem_arb_pkg.sv
// Shared types and constants for the sdatamem port arbiter.
package sdmem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_VEC} state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_SCALAR, GNT_VECTOR} grant_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/sdmem_vec_agen.sv
// Vector burst address generator: element address, index and remaining count.
module sdmem_vec_agen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] stride,
  input  logic [CNT_W-1:0]      count,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [CNT_W-1:0]      idx,
  output logic [CNT_W-1:0]      rem,
  output logic                  last
);

  // Signed stride adds modulo 2^DATA_WIDTH, so plain unsigned addition wraps correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      idx  <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= base;
      idx  <= '0;
      rem  <= count;
    end else if (advance) begin
      addr <= addr + stride;
      idx  <= idx + CNT_W'(1);
      rem  <= rem - CNT_W'(1);
    end
  end

  assign last = (rem == CNT_W'(1));

endmodule

// File: rtl/sdmem_arbiter.sv
// Arbitrates the single sdatamem port between scalar accesses and expanded vector bursts.
// Optional bounds/alignment check enabled by defining SDMEM_ARB_BOUNDS_EN.
module sdmem_arbiter
  import sdmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_VL     = 64,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned CNT_W      = $clog2(MAX_VL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req_valid_i,
  output logic                  s_req_ready_o,
  input  logic                  s_we_i,
  input  logic [1:0]            s_size_i,
  input  logic [DATA_WIDTH-1:0] s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  output logic                  s_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] s_rsp_rdata_o,
  input  logic                  v_req_valid_i,
  output logic                  v_req_ready_o,
  input  logic                  v_we_i,
  input  logic [1:0]            v_size_i,
  input  logic [DATA_WIDTH-1:0] v_base_i,
  input  logic [DATA_WIDTH-1:0] v_stride_i,
  input  logic [CNT_W-1:0]      v_count_i,
  input  logic                  v_wdata_valid_i,
  output logic                  v_wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] v_wdata_i,
  output logic                  v_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] v_rsp_rdata_o,
  output logic [CNT_W-1:0]      v_rsp_idx_o,
  output logic                  v_done_o,
  output logic                  rsp_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

`ifdef SDMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_SIZE - 3);

  state_e                  state_q, state_d;
  grant_e                  gnt;
  logic                    rr_vec_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    accept;
  logic                    s_cand, v_cand;
  logic [DATA_WIDTH-1:0]   v_addr;
  logic [CNT_W-1:0]        v_idx, v_rem;
  logic                    v_last;
  logic [DATA_WIDTH-1:0]   acc_addr, acc_wdata;
  logic [1:0]              acc_size;
  logic                    acc_we, bad, go;

  sdmem_vec_agen #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_agen (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && (v_count_i != '0)),
    .base   (v_base_i),
    .stride (v_stride_i),
    .count  (v_count_i),
    .advance(gnt == GNT_VECTOR),
    .addr   (v_addr),
    .idx    (v_idx),
    .rem    (v_rem),
    .last   (v_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Grant selection and next state; nothing is granted while reset is held.
  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    accept  = 1'b0;
    s_cand  = s_req_valid_i;
    v_cand  = (state_q == ST_VEC) && (v_rem != '0) && (!we_q || v_wdata_valid_i);
    if (!rst) begin
      if (s_cand && v_cand) gnt = rr_vec_q ? GNT_SCALAR : GNT_VECTOR;
      else if (s_cand)      gnt = GNT_SCALAR;
      else if (v_cand)      gnt = GNT_VECTOR;
      accept = (state_q == ST_IDLE) && v_req_valid_i;
    end
    if (accept && (v_count_i != '0)) state_d = ST_VEC;
    if ((gnt == GNT_VECTOR) && v_last) state_d = ST_IDLE;
  end

  // Memory port mux; a rejected access is still granted but never reaches memory.
  always_comb begin
    acc_addr  = (gnt == GNT_VECTOR) ? v_addr    : s_addr_i;
    acc_wdata = (gnt == GNT_VECTOR) ? v_wdata_i : s_wdata_i;
    acc_size  = (gnt == GNT_VECTOR) ? size_q    : s_size_i;
    acc_we    = (gnt == GNT_VECTOR) ? we_q      : s_we_i;
    bad       = BOUNDS_EN && ((acc_addr >= ADDR_LIMIT) ||
                              ((acc_size == SZ_HALF) && acc_addr[0]) ||
                              (acc_size[1] && (acc_addr[1:0] != 2'b00)));
    go          = (gnt != GNT_NONE) && !bad;
    mem_read_o  = go && !acc_we;
    mem_write_o = go && acc_we;
    mem_addr_o  = go ? acc_addr  : '0;
    mem_wdata_o = go ? acc_wdata : '0;
    mem_size_o  = go ? acc_size  : 2'b00;
  end

  assign s_req_ready_o   = (gnt == GNT_SCALAR);
  assign v_req_ready_o   = (state_q == ST_IDLE) && !rst;
  assign v_wdata_ready_o = (gnt == GNT_VECTOR) && we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_vec_q      <= 1'b1;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      s_rsp_valid_o <= 1'b0;
      s_rsp_rdata_o <= '0;
      v_rsp_valid_o <= 1'b0;
      v_rsp_rdata_o <= '0;
      v_rsp_idx_o   <= '0;
      v_done_o      <= 1'b0;
      rsp_err_o     <= 1'b0;
    end else begin
      s_rsp_valid_o <= (gnt == GNT_SCALAR);
      s_rsp_rdata_o <= ((gnt == GNT_SCALAR) && mem_read_o) ? mem_rdata_i : '0;
      v_rsp_valid_o <= (gnt == GNT_VECTOR);
      v_rsp_rdata_o <= ((gnt == GNT_VECTOR) && mem_read_o) ? mem_rdata_i : '0;
      v_rsp_idx_o   <= (gnt == GNT_VECTOR) ? v_idx : '0;
      v_done_o      <= ((gnt == GNT_VECTOR) && v_last) || (accept && (v_count_i == '0));
      rsp_err_o     <= (gnt != GNT_NONE) && bad;
      if (gnt != GNT_NONE) rr_vec_q <= (gnt == GNT_VECTOR);
      if (accept) begin
        we_q   <= v_we_i;
        size_q <= v_size_i;
      end
    end
  end

endmodule
